game_flow_controller: RTL and testbench

- Top-level game sequencer that sits directly upstream of the level controller.
- Drives the controller's enable, cycleLevel and oneSecPulse inputs, and consumes its stageEnded/stageFailed outputs.
- Owns the title → play → stage-clear → game-over/victory flow, the current level index, and the 1 Hz tick.
- Also emits a screen-select code for the top-level video mux.

---
 rtl/game_flow_pkg.sv | 36 +++
 rtl/game_flow_controller_if.sv | 40 ++++
 rtl/game_flow_controller_one_sec_tick.sv | 45 ++++
 rtl/game_flow_controller.sv | 128 ++++++++++++
 tb/tb_game_flow_controller.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/game_flow_pkg.sv
// Shared types and constants for the game flow sequencer.
package game_flow_pkg;

  localparam int LVL_W = 4;
  localparam int SCR_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    CLEAR,
    OVER,
    WIN
  } flow_state_t;

  localparam logic [SCR_W-1:0] SCR_TITLE = 3'd0;
  localparam logic [SCR_W-1:0] SCR_PLAY  = 3'd1;
  localparam logic [SCR_W-1:0] SCR_CLEAR = 3'd2;
  localparam logic [SCR_W-1:0] SCR_OVER  = 3'd3;
  localparam logic [SCR_W-1:0] SCR_WIN   = 3'd4;

  // Screen shown by the video mux for a given flow state.
  function automatic logic [SCR_W-1:0] screenFor(input flow_state_t s);
    logic [SCR_W-1:0] scr;
    scr = SCR_TITLE;
    case (s)
      IDLE:    scr = SCR_TITLE;
      PLAY:    scr = SCR_PLAY;
      CLEAR:   scr = SCR_CLEAR;
      OVER:    scr = SCR_OVER;
      WIN:     scr = SCR_WIN;
      default: scr = SCR_TITLE;
    endcase
    return scr;
  endfunction

endpackage

// File: rtl/game_flow_controller_if.sv
// Bundle between the game sequencer and its neighbours: player key,
// level controller handshake and display outputs.
interface game_flow_controller_if;
  import game_flow_pkg::*;

  logic             startKey;
  logic             stageEnded;
  logic             stageFailed;
  logic             levelEnable;
  logic             cycleLevel;
  logic             oneSecPulse;
  logic [LVL_W-1:0] levelIndex;
  logic [SCR_W-1:0] screenSel;
  logic [LVL_W-1:0] countdown;

  modport master (
    input  startKey,
    input  stageEnded,
    input  stageFailed,
    output levelEnable,
    output cycleLevel,
    output oneSecPulse,
    output levelIndex,
    output screenSel,
    output countdown
  );

  modport slave (
    output startKey,
    output stageEnded,
    output stageFailed,
    input  levelEnable,
    input  cycleLevel,
    input  oneSecPulse,
    input  levelIndex,
    input  screenSel,
    input  countdown
  );

endinterface

// File: rtl/game_flow_controller_one_sec_tick.sv
// Prescaler producing a registered one-cycle tick every CLK_FREQ_HZ cycles
// while run is high; restart realigns the count to zero.
module one_sec_tick #(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_FREQ_HZ - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next count: held at zero when idle or restarting, wraps with a tick.
  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (run && !restart) begin
      if (cnt_q == LAST) begin
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Prescaler and tick registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/game_flow_controller.sv
// Top-level game sequencer: title, play, stage-clear countdown, game-over and
// victory screens, plus the level index and 1 Hz tick for the level controller.
module game_flow_controller
  import game_flow_pkg::*;
#(
  parameter int CLK_FREQ_HZ        = 50_000_000,
  parameter int NUM_LEVELS         = 3,
  parameter int INTERSTAGE_SECONDS = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  game_flow_controller_if.master flowIf
);

  localparam logic [LVL_W-1:0] LAST_LEVEL = LVL_W'(NUM_LEVELS - 1);
  localparam logic [LVL_W-1:0] CLEAR_SECS = LVL_W'(INTERSTAGE_SECONDS);

  flow_state_t      state_q, state_d;
  logic [LVL_W-1:0] levelIndex_q, levelIndex_d;
  logic [LVL_W-1:0] countdown_q, countdown_d;
  logic             cycleLevel_q, cycleLevel_d;
  logic             levelEnable_q, levelEnable_d;
  logic [SCR_W-1:0] screenSel_q, screenSel_d;
  logic             startKey_q;
  logic             startEdge;
  logic             tick;
  logic             tickRun;
  logic             tickRestart;

  // The edge register keeps following the key even during reset, so a key
  // held through reset does not look like a fresh press afterwards.
  always_ff @(posedge clk) begin
    startKey_q <= flowIf.startKey;
  end

  assign startEdge = flowIf.startKey & ~startKey_q;

  assign tickRun     = (state_d == PLAY) || (state_d == CLEAR);
  assign tickRestart = (state_d != state_q);

  one_sec_tick #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .run    (tickRun),
    .restart(tickRestart),
    .tick   (tick)
  );

  // Next-state, level index and countdown decisions.
  always_comb begin
    state_d      = state_q;
    levelIndex_d = levelIndex_q;
    countdown_d  = countdown_q;
    cycleLevel_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (startEdge) begin
          state_d      = PLAY;
          levelIndex_d = '0;
        end
      end
      PLAY: begin
        if (flowIf.stageFailed) begin
          state_d = OVER;
        end else if (flowIf.stageEnded) begin
          if (levelIndex_q == LAST_LEVEL) begin
            state_d = WIN;
          end else begin
            state_d     = CLEAR;
            countdown_d = CLEAR_SECS;
          end
        end
      end
      CLEAR: begin
        if (startEdge || (tick && countdown_q == 4'd1)) begin
          state_d      = PLAY;
          levelIndex_d = levelIndex_q + 1'b1;
          countdown_d  = '0;
          cycleLevel_d = 1'b1;
        end else if (tick && countdown_q != 4'd0) begin
          countdown_d = countdown_q - 1'b1;
        end
      end
      OVER, WIN: begin
        if (startEdge) begin
          state_d      = IDLE;
          levelIndex_d = '0;
        end
      end
      default: begin
        state_d      = IDLE;
        levelIndex_d = '0;
        countdown_d  = '0;
      end
    endcase
    levelEnable_d = (state_d == PLAY);
    screenSel_d   = screenFor(state_d);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      levelIndex_q  <= '0;
      countdown_q   <= '0;
      cycleLevel_q  <= 1'b0;
      levelEnable_q <= 1'b0;
      screenSel_q   <= SCR_TITLE;
    end else begin
      state_q       <= state_d;
      levelIndex_q  <= levelIndex_d;
      countdown_q   <= countdown_d;
      cycleLevel_q  <= cycleLevel_d;
      levelEnable_q <= levelEnable_d;
      screenSel_q   <= screenSel_d;
    end
  end

  assign flowIf.levelEnable = levelEnable_q;
  assign flowIf.cycleLevel  = cycleLevel_q;
  assign flowIf.oneSecPulse = tick;
  assign flowIf.levelIndex  = levelIndex_q;
  assign flowIf.screenSel   = screenSel_q;
  assign flowIf.countdown   = countdown_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for the game sequencer: directed walk through the game flow followed
// by random key/stage/reset traffic, all compared against a screen-level model.
module tb_game_flow_controller;

  localparam int CF = 10;
  localparam int NL = 2;
  localparam int IS = 2;

  localparam int S_TITLE = 0;
  localparam int S_PLAY  = 1;
  localparam int S_CLEAR = 2;
  localparam int S_OVER  = 3;
  localparam int S_WIN   = 4;

  logic clk = 1'b0;
  logic reset;

  game_flow_controller_if flowBus();

  game_flow_controller #(
    .CLK_FREQ_HZ       (CF),
    .NUM_LEVELS        (NL),
    .INTERSTAGE_SECONDS(IS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flowIf(flowBus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model, expressed as "which screen is up" plus plain counters.
  int mScreen  = S_TITLE;
  int mLevel   = 0;
  int mCount   = 0;
  int mElapsed = 0;
  int mPulse   = 0;
  int mCycle   = 0;
  int mKeyPrev = 0;

  logic keyLevel = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: observed %0d, expected %0d",
               tag, $time, observed, expected);
    end
  endtask

  // One clock edge of the game rules applied to the inputs seen at that edge.
  task automatic modelStep(input int r, input int k, input int e, input int f);
    int pressed;
    int nextScreen;
    pressed  = (k != 0) && (mKeyPrev == 0);
    mKeyPrev = k;
    mCycle   = 0;
    if (r != 0) begin
      mScreen  = S_TITLE;
      mLevel   = 0;
      mCount   = 0;
      mElapsed = 0;
      mPulse   = 0;
      return;
    end
    nextScreen = mScreen;
    case (mScreen)
      S_TITLE: if (pressed != 0) begin nextScreen = S_PLAY; mLevel = 0; end
      S_PLAY: begin
        if (f != 0) nextScreen = S_OVER;
        else if (e != 0) begin
          if (mLevel == NL - 1) nextScreen = S_WIN;
          else begin nextScreen = S_CLEAR; mCount = IS; end
        end
      end
      S_CLEAR: begin
        if (pressed != 0 || (mPulse != 0 && mCount == 1)) begin
          nextScreen = S_PLAY;
          mLevel++;
          mCount = 0;
          mCycle = 1;
        end else if (mPulse != 0) begin
          mCount--;
        end
      end
      default: if (pressed != 0) begin nextScreen = S_TITLE; mLevel = 0; end
    endcase
    if (nextScreen != mScreen) mElapsed = 0;
    else if (mScreen == S_PLAY || mScreen == S_CLEAR) mElapsed++;
    else mElapsed = 0;
    mScreen = nextScreen;
    mPulse  = ((mScreen == S_PLAY || mScreen == S_CLEAR) &&
               mElapsed > 0 && (mElapsed % CF) == 0) ? 1 : 0;
  endtask

  task automatic applyStimulus(input logic r, input logic k, input logic e,
                               input logic f);
    reset               = r;
    flowBus.startKey    = k;
    flowBus.stageEnded  = e;
    flowBus.stageFailed = f;
    @(posedge clk);
    modelStep(int'(r), int'(k), int'(e), int'(f));
    #1;
    checkOutput("screenSel",   32'(flowBus.screenSel),   32'(mScreen));
    checkOutput("levelEnable", 32'(flowBus.levelEnable), 32'(mScreen == S_PLAY));
    checkOutput("cycleLevel",  32'(flowBus.cycleLevel),  32'(mCycle));
    checkOutput("oneSecPulse", 32'(flowBus.oneSecPulse), 32'(mPulse));
    checkOutput("levelIndex",  32'(flowBus.levelIndex),  32'(mLevel));
    checkOutput("countdown",   32'(flowBus.countdown),   32'(mCount));
  endtask

  task automatic runCycles(input int n, input logic k);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, k, 1'b0, 1'b0);
  endtask

  initial begin
    reset               = 1'b1;
    flowBus.startKey    = 1'b0;
    flowBus.stageEnded  = 1'b0;
    flowBus.stageFailed = 1'b0;

    // Reset, then start and watch the 1 Hz tick in PLAY.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runCycles(2, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    runCycles(25, 1'b1);

    // Level advance through the full countdown.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    runCycles(22, 1'b0);

    // Victory on the last level, silence, then back to the title.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    runCycles(15, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    runCycles(2, 1'b0);

    // Skip the countdown with a key press that lands on a tick.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    runCycles(2, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    runCycles(10, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    runCycles(3, 1'b0);

    // Fail takes priority over a coincident stage end.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    runCycles(12, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    runCycles(2, 1'b0);

    // Reset mid-countdown with the key held through and after reset.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    runCycles(2, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    runCycles(4, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    runCycles(5, 1'b1);
    runCycles(1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    runCycles(3, 1'b1);

    // Random traffic: key toggles, stage pulses, stray pulses and resets.
    keyLevel = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic r, e, f;
      if ($urandom_range(0, 7) == 0) keyLevel = ~keyLevel;
      e = ($urandom_range(0, 29) == 0);
      f = ($urandom_range(0, 59) == 0);
      r = ($urandom_range(0, 399) == 0);
      applyStimulus(r, keyLevel, e, f);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
